dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage memory request.
- Accepts the load/store request driven by the EXE/MEM pipeline register: address, store data, store size, read/write enables.
- Performs the access on an internal word-organised RAM with byte lanes, after a configurable number of wait states.
- Returns the raw 32-bit read word for the MEM/WB register, a stall signal for the hazard unit, and registered address-error flags for the exception logic.

Parameters:
- ADDR_WIDTH, 10, number of word-address bits; the RAM holds 2^ADDR_WIDTH words.
- WAIT_CYCLES, 1, extra cycles between request acceptance and the RAM access edge; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- MEM_Req  input  1  request valid; held stable by the pipeline while MEM_DMBusy=1.
- MEM_DMWr  input  1  store request.
- MEM_ReadMem  input  1  load request.
- MEM_ALUOut  input  32  byte address.
- MEM_OutB  input  32  store data, right-aligned.
- MEM_StoreSize  input  2  access size for stores and loads: 00 byte, 01 half, 10 word; 11 is treated as word.
- MEM_Flush  input  1  abort the current request.
- MEM_DMOut  output  32  raw aligned read word.
- MEM_DMBusy  output  1  stall request to the hazard unit.
- MEM_DMDone  output  1  one-cycle completion pulse.
- MEM_RdAddrErr  output  1  load address misaligned; registered, valid with MEM_DMDone.
- MEM_WrAddrErr  output  1  store address misaligned; registered, valid with MEM_DMDone.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE, wait counter 0.
  - MEM_DMOut = 0, MEM_RdAddrErr = 0, MEM_WrAddrErr = 0.
  - MEM_DMBusy and MEM_DMDone are low in the cycle after reset.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - MEM_Req=1 with no flush accepts the request and latches address, data, size and kind.
  - Kind rule: DMWr=1 is a store, with priority over ReadMem; ReadMem=1 alone is a load; neither is a no-op.
  - Transition: WAIT_CYCLES=0 performs the access at this edge and goes to RESP. Otherwise the counter loads WAIT_CYCLES and the state goes to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 1, the access is performed at that edge and the state goes to RESP.
- RESP:
  - MEM_DMDone=1 for exactly one cycle, then IDLE.
  - MEM_Req is ignored in RESP: the held instruction leaves the stage at the end of this cycle.
- Busy and done:
  - MEM_DMBusy = (IDLE & MEM_Req & ~MEM_Flush) | WAIT.
  - MEM_DMDone = RESP & ~MEM_Flush.
- Latency: the done pulse occurs WAIT_CYCLES+1 cycles after the acceptance cycle.
- Misalignment check (at acceptance):
  - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned request performs no RAM access and skips WAIT, going straight to RESP.
  - MEM_RdAddrErr or MEM_WrAddrErr is set according to kind; both flags clear at the next acceptance.
  - A misaligned no-op sets neither flag.
- Indexing: RAM index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap.
- Store byte enables and data:
  - Byte: be = 0001 << addr[1:0]; data = {4{OutB[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; data = {2{OutB[15:0]}}.
  - Word: be = 1111; data = OutB.
  - Only enabled lanes are written.
- Loads:
  - The full word at the index is registered into MEM_DMOut at the access edge.
  - Sign/zero extension and lane selection are done downstream in WB.
  - MEM_DMOut holds its value until the next load access; stores and no-ops do not change it.
- Flush:
  - Flush in IDLE: nothing is accepted.
  - Flush in WAIT: state returns to IDLE, no RAM write, no done.
  - Flush in RESP: done is suppressed and state returns to IDLE; an access already performed is not undone.
- Reset mid-operation: any pending access not yet at its access edge is discarded, with no partial write.
- Simultaneous load-after-store: the second request is accepted only in IDLE after the first has left RESP, so it always sees the stored data.

Test Plan:
- SW, WAIT_CYCLES=0, addr 0x00000010, data 0xDEADBEEF, then LW same address:
  - MEM_DMBusy=1 for 1 cycle, MEM_DMDone the next cycle.
  - LW returns MEM_DMOut=0xDEADBEEF.
- SB data 0x000000A5 to addr 0x00000013 over word 0x11223344, then LW 0x10 -> MEM_DMOut=0xA5223344.
- SH to 0x00000021 -> no write; MEM_WrAddrErr=1 with MEM_DMDone after 1 cycle, no WAIT; a following LW 0x20 returns the unchanged word.
- WAIT_CYCLES=2, LW: MEM_DMBusy high for exactly 3 cycles, MEM_DMDone in the 4th cycle after acceptance, MEM_DMOut updated at the same time.
- WAIT_CYCLES=2, SW 0x12345678 to 0x40, MEM_Flush during WAIT -> no MEM_DMDone; LW 0x40 returns the old value.
- rst asserted during WAIT of a SW -> after reset all outputs are 0, state IDLE; LW shows the old value; MEM_DMOut=0 before that load completes.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: byte-lane word RAM behind a
// configurable wait-state FSM, with registered read data and address-error flags.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Req,
  input  logic        MEM_DMWr,
  input  logic        MEM_ReadMem,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_OutB,
  input  logic [1:0]  MEM_StoreSize,
  input  logic        MEM_Flush,
  output logic [31:0] MEM_DMOut,
  output logic        MEM_DMBusy,
  output logic        MEM_DMDone,
  output logic        MEM_RdAddrErr,
  output logic        MEM_WrAddrErr,
  output logic [1:0]  o_dbg_state
);

  localparam int         DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [3:0] LP_WAIT    = 4'(WAIT_CYCLES);
  localparam logic       LP_NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_data;
  logic [1:0]            r_size;
  logic                  r_is_st, r_is_ld;
  logic [31:0]           r_dmout;
  logic                  r_rd_err, r_wr_err;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_idle, w_accept, w_in_st, w_in_ld, w_misalign;
  logic                  w_st, w_ld, w_access;
  logic [ADDR_WIDTH+1:0] w_addr;
  logic [31:0]           w_data, w_wdata;
  logic [1:0]            w_size;
  logic [3:0]            w_be;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_busy, w_done;
  logic                  w_unused_addr;

  // Handshake: a request is taken when MEM_Req is high in IDLE without flush;
  // the pipeline must hold it stable while MEM_DMBusy is high.
  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = w_idle & MEM_Req & ~MEM_Flush;
  assign w_in_st    = MEM_DMWr;
  assign w_in_ld    = ~MEM_DMWr & MEM_ReadMem;
  assign w_misalign = ((MEM_StoreSize == 2'b01) & MEM_ALUOut[0]) |
                      (MEM_StoreSize[1] & (|MEM_ALUOut[1:0]));

  // With no wait states the access happens on the acceptance edge, straight from the inputs.
  assign w_addr = w_idle ? MEM_ALUOut[ADDR_WIDTH+1:0] : r_addr;
  assign w_data = w_idle ? MEM_OutB : r_data;
  assign w_size = w_idle ? MEM_StoreSize : r_size;
  assign w_st   = w_idle ? w_in_st : r_is_st;
  assign w_ld   = w_idle ? w_in_ld : r_is_ld;
  assign w_idx  = w_addr[ADDR_WIDTH+1:2];

  assign w_unused_addr = ^MEM_ALUOut[31:ADDR_WIDTH+2];

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_data;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{w_data[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = w_data;
      end
    endcase
  end

  assign w_access = ~rst & ((w_accept & ~w_misalign & LP_NO_WAIT) |
                            ((r_state == S_WAIT) & (r_cnt == 4'd1) & ~MEM_Flush));

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_busy = 1'b1;
          w_next = (w_misalign || LP_NO_WAIT) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (MEM_Flush)          w_next = S_IDLE;
        else if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        w_done = ~MEM_Flush;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_dmout  <= 32'd0;
      r_rd_err <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt    <= LP_WAIT;
        r_rd_err <= w_misalign & w_in_ld;
        r_wr_err <= w_misalign & w_in_st;
      end else if (r_state == S_WAIT) begin
        r_cnt <= MEM_Flush ? 4'd0 : r_cnt - 4'd1;
      end
      if (w_access && w_ld) r_dmout <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= MEM_ALUOut[ADDR_WIDTH+1:0];
      r_data  <= MEM_OutB;
      r_size  <= MEM_StoreSize;
      r_is_st <= w_in_st;
      r_is_ld <= w_in_ld;
    end
  end

  // RAM is never reset; w_access is already gated by rst so no partial write escapes.
  always_ff @(posedge clk) begin
    if (w_access && w_st) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign MEM_DMOut     = r_dmout;
  assign MEM_DMBusy    = w_busy;
  assign MEM_DMDone    = w_done;
  assign MEM_RdAddrErr = r_rd_err;
  assign MEM_WrAddrErr = r_wr_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 2 wait states) checked against a
// byte-array memory model with directed plan steps and randomized load/store traffic.
module tb_dmem_responder;

  localparam int WC0 = 0;
  localparam int WC1 = 2;

  logic        clk;
  logic        rst;
  logic        req[2], wr[2], rd[2], flush[2];
  logic [31:0] alu[2], outb[2];
  logic [1:0]  sz[2];
  logic [31:0] dout[2];
  logic        busy[2], done[2], rerr[2], werr[2];
  logic [1:0]  dbg[2];

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_mem [2][4096];
  logic [31:0] m_dout[2];

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC0)) u_dut0 (
    .clk(clk), .rst(rst), .MEM_Req(req[0]), .MEM_DMWr(wr[0]), .MEM_ReadMem(rd[0]),
    .MEM_ALUOut(alu[0]), .MEM_OutB(outb[0]), .MEM_StoreSize(sz[0]), .MEM_Flush(flush[0]),
    .MEM_DMOut(dout[0]), .MEM_DMBusy(busy[0]), .MEM_DMDone(done[0]),
    .MEM_RdAddrErr(rerr[0]), .MEM_WrAddrErr(werr[0]), .o_dbg_state(dbg[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC1)) u_dut1 (
    .clk(clk), .rst(rst), .MEM_Req(req[1]), .MEM_DMWr(wr[1]), .MEM_ReadMem(rd[1]),
    .MEM_ALUOut(alu[1]), .MEM_OutB(outb[1]), .MEM_StoreSize(sz[1]), .MEM_Flush(flush[1]),
    .MEM_DMOut(dout[1]), .MEM_DMBusy(busy[1]), .MEM_DMDone(done[1]),
    .MEM_RdAddrErr(rerr[1]), .MEM_WrAddrErr(werr[1]), .o_dbg_state(dbg[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] model_word(input int s, input logic [31:0] a);
    int b;
    b = int'(a[11:2]) * 4;
    return {m_mem[s][b+3], m_mem[s][b+2], m_mem[s][b+1], m_mem[s][b]};
  endfunction

  // driver: one complete request, checked for latency, busy length, data and flags
  task automatic txn(input int s, input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] z);
    int          n, busy_n, done_at, wc, base;
    logic        mis;
    logic [31:0] o_dout;
    logic        o_rerr, o_werr;
    n       = (z == 2'd0) ? 1 : (z == 2'd1) ? 2 : 4;
    mis     = (a % n) != 0;
    wc      = (s == 0) ? WC0 : WC1;
    busy_n  = 0;
    done_at = -1;
    o_dout  = 'x;
    o_rerr  = 1'bx;
    o_werr  = 1'bx;
    @(negedge clk);
    req[s] = 1'b1; wr[s] = w; rd[s] = r; alu[s] = a; outb[s] = d; sz[s] = z;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c == 0) chk("dout_hold", dout[s], m_dout[s]);
      if (done[s]) begin
        done_at = c;
        o_dout  = dout[s];
        o_rerr  = rerr[s];
        o_werr  = werr[s];
        break;
      end
      if (busy[s]) busy_n++;
      @(negedge clk);
    end
    req[s] = 1'b0; wr[s] = 1'b0; rd[s] = 1'b0;
    if (!mis) begin
      if (w) begin
        base = int'(a[11:0]);
        for (int i = 0; i < n; i++) m_mem[s][base + i] = d[8*i +: 8];
      end else if (r) begin
        m_dout[s] = model_word(s, a);
      end
    end
    chk("done_latency", done_at, mis ? 1 : wc + 1);
    chk("busy_cycles", busy_n, mis ? 1 : wc + 1);
    chk("dout", o_dout, m_dout[s]);
    chk("rd_err", o_rerr, mis & ~w & r);
    chk("wr_err", o_werr, mis & w);
  endtask

  initial begin
    int          s, k, lane, idx;
    logic [1:0]  z;
    logic [31:0] a;
    logic        seen;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; rd[i] = 1'b0; flush[i] = 1'b0;
      alu[i] = '0; outb[i] = '0; sz[i] = '0; m_dout[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_dout", dout[i], 32'd0);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_done", done[i], 1'b0);
      chk("rst_rerr", rerr[i], 1'b0);
      chk("rst_werr", werr[i], 1'b0);
    end

    // preload the first 64 words of each RAM so every later load has a known value
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) txn(i, 1'b1, 1'b0, 32'(j * 4), $urandom, 2'd2);

    // zero-wait word store then load
    txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'd2);
    txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 2'd2);
    chk("lw_deadbeef", dout[0], 32'hDEADBEEF);

    // byte store into lane 3
    txn(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 2'd2);
    txn(0, 1'b1, 1'b0, 32'h13, 32'h000000A5, 2'd0);
    txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 2'd2);
    chk("sb_lane3", dout[0], 32'hA5223344);

    // misaligned half store, then the word must be unchanged
    txn(0, 1'b1, 1'b0, 32'h21, 32'hFFFF, 2'd1);
    txn(0, 1'b0, 1'b1, 32'h20, 32'h0, 2'd2);

    // two wait states: word store then load
    txn(1, 1'b1, 1'b0, 32'h30, 32'h5A5A0FF0, 2'd2);
    txn(1, 1'b0, 1'b1, 32'h30, 32'h0, 2'd2);
    chk("lw_wait2", dout[1], 32'h5A5A0FF0);

    // flush during WAIT: no done, no write
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; rd[1] = 1'b0; alu[1] = 32'h40; outb[1] = 32'h12345678; sz[1] = 2'd2;
    @(negedge clk);
    flush[1] = 1'b1;
    #1;
    chk("flushw_busy", busy[1], 1'b1);
    seen = done[1];
    @(negedge clk);
    req[1] = 1'b0; wr[1] = 1'b0; flush[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      seen |= done[1];
      if (c == 0) chk("flushw_idle_busy", busy[1], 1'b0);
      @(negedge clk);
    end
    chk("flushw_no_done", seen, 1'b0);
    txn(1, 1'b0, 1'b1, 32'h40, 32'h0, 2'd2);

    // flush during RESP: done suppressed, the write already happened
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; rd[0] = 1'b0; alu[0] = 32'h80; outb[0] = 32'h0BADCAFE; sz[0] = 2'd2;
    #1;
    chk("flushr_busy", busy[0], 1'b1);
    @(negedge clk);
    req[0] = 1'b0; wr[0] = 1'b0; flush[0] = 1'b1;
    #1;
    chk("flushr_done", done[0], 1'b0);
    @(negedge clk);
    flush[0] = 1'b0;
    #1;
    chk("flushr_after", done[0] | busy[0], 1'b0);
    for (int i = 0; i < 4; i++) m_mem[0][128 + i] = 8'(32'h0BADCAFE >> (8 * i));
    txn(0, 1'b0, 1'b1, 32'h80, 32'h0, 2'd2);
    chk("flushr_kept", dout[0], 32'h0BADCAFE);

    // flush in IDLE: nothing accepted
    @(negedge clk);
    req[0] = 1'b1; rd[0] = 1'b1; alu[0] = 32'h10; sz[0] = 2'd2; flush[0] = 1'b1;
    #1;
    chk("flushi_busy", busy[0], 1'b0);
    @(negedge clk);
    #1;
    chk("flushi_done", done[0] | busy[0], 1'b0);
    req[0] = 1'b0; rd[0] = 1'b0; flush[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("flushi_done2", done[0], 1'b0);

    // randomized traffic, upper address bits randomized to exercise wrap
    for (int t = 0; t < 200; t++) begin
      s    = $urandom_range(0, 1);
      k    = $urandom_range(0, 4);
      idx  = $urandom_range(0, 63);
      lane = $urandom_range(0, 3);
      z    = 2'($urandom_range(0, 3));
      a    = ($urandom & 32'hFFFF_F000) | 32'(idx * 4 + lane);
      case (k)
        0:       txn(s, 1'b1, 1'b0, a, $urandom, z);
        1, 2:    txn(s, 1'b0, 1'b1, a, $urandom, z);
        3:       txn(s, 1'b1, 1'b1, a, $urandom, z);
        default: txn(s, 1'b0, 1'b0, a, $urandom, z);
      endcase
    end

    // reset in the middle of a waiting store
    txn(1, 1'b0, 1'b1, 32'h44, 32'h0, 2'd2);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; rd[1] = 1'b0; alu[1] = 32'h44; outb[1] = 32'hCAFEF00D; sz[1] = 2'd2;
    @(negedge clk);
    rst = 1'b1; req[1] = 1'b0; wr[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_dout[0] = '0;
    m_dout[1] = '0;
    #1;
    chk("mrst_dout", dout[1], 32'd0);
    chk("mrst_busy", busy[1], 1'b0);
    chk("mrst_done", done[1], 1'b0);
    chk("mrst_errs", {rerr[1], werr[1]}, 2'b00);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      seen |= done[1];
    end
    chk("mrst_no_done", seen, 1'b0);
    txn(1, 1'b0, 1'b1, 32'h44, 32'h0, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
